// File: rtl/alu_exec_seq_pkg.sv
// Shared definitions for the multi-cycle execute stage: ALU op codes and
// sequencer state encoding.
package alu_exec_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_A = 3'd1,
    S_FETCH_B = 3'd2,
    S_EXEC    = 3'd3,
    S_WRITE   = 3'd4
  } state_t;

endpackage

// File: rtl/alu_exec_seq_alu_core.sv
// Purely combinational ALU: n-bit wrap-around result plus zero and
// carry/borrow/shift-out flags.
module alu_core
  import alu_exec_seq_pkg::*;
#(
  parameter int n = 16
) (
  input  logic [2:0]   op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] result,
  output logic         zero,
  output logic         carry
);

  logic [n:0] wide;

  // Compute an (n+1)-bit value so the extra bit carries carry/borrow out.
  always_comb begin
    wide  = {(n+1){1'b0}};
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        carry = wide[n];
      end
      OP_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        carry = wide[n];
      end
      OP_AND: wide = {1'b0, a & b};
      OP_OR:  wide = {1'b0, a | b};
      OP_XOR: wide = {1'b0, a ^ b};
      OP_NOT: wide = {1'b0, ~a};
      OP_SHL: begin
        wide  = {a, 1'b0};
        carry = a[n-1];
      end
      OP_SHR: begin
        wide  = {2'b00, a[n-1:1]};
        carry = a[0];
      end
      default: begin
        wide  = {(n+1){1'b0}};
        carry = 1'b0;
      end
    endcase
    result = wide[n-1:0];
    zero   = (wide[n-1:0] == {n{1'b0}});
  end

endmodule

// File: rtl/alu_exec_seq.sv
// Multi-cycle execute stage: fetches two operands through a single read
// port, runs the ALU, then writes the result back with zero/carry flags.
module alu_exec_seq
  import alu_exec_seq_pkg::*;
#(
  parameter int m = 2,
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [m-1:0] srcA,
  input  logic [m-1:0] srcB,
  input  logic [m-1:0] dest,
  input  logic [n-1:0] regData,
  output logic [m-1:0] readAddr,
  output logic [m-1:0] writeAddr,
  output logic         writeEnable,
  output logic [n-1:0] dataOut,
  output logic         busy,
  output logic         done,
  output logic         zeroFlag,
  output logic         carryFlag
);

  state_t       state;
  state_t       state_next;
  logic [2:0]   op_q;
  logic [m-1:0] src_b_q;
  logic [m-1:0] dest_q;
  logic [n-1:0] opa;
  logic [n-1:0] opb;
  logic [n-1:0] alu_result;
  logic         alu_zero;
  logic         alu_carry;

  alu_core #(.n(n)) u_alu (
    .op     (op_q),
    .a      (opa),
    .b      (opb),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fixed-latency sequence; start is only looked at in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH_A;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_FETCH_A: state_next = S_FETCH_B;
      S_FETCH_B: state_next = S_EXEC;
      S_EXEC:    state_next = S_WRITE;
      S_WRITE:   state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Datapath and registered outputs; readAddr is set one edge early so it
  // is stable for the whole fetch cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      op_q        <= 3'b000;
      src_b_q     <= {m{1'b0}};
      dest_q      <= {m{1'b0}};
      opa         <= {n{1'b0}};
      opb         <= {n{1'b0}};
      readAddr    <= {m{1'b0}};
      writeAddr   <= {m{1'b0}};
      dataOut     <= {n{1'b0}};
      writeEnable <= 1'b0;
      done        <= 1'b0;
      zeroFlag    <= 1'b0;
      carryFlag   <= 1'b0;
    end else begin
      writeEnable <= (state == S_EXEC);
      done        <= (state == S_WRITE);
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q     <= op;
            src_b_q  <= srcB;
            dest_q   <= dest;
            readAddr <= srcA;
          end
        end
        S_FETCH_A: begin
          opa      <= regData;
          readAddr <= src_b_q;
        end
        S_FETCH_B: begin
          opb <= regData;
        end
        S_EXEC: begin
          writeAddr <= dest_q;
          dataOut   <= alu_result;
          zeroFlag  <= alu_zero;
          carryFlag <= alu_carry;
        end
        S_WRITE: begin
          op_q <= op_q;
        end
        default: begin
          op_q <= op_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed self-checking bench for alu_exec_seq with a 4x16 register array
// model (combinational read, negedge write).
module tb_alu_exec_seq;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [1:0]  srcA = 2'd0;
  logic [1:0]  srcB = 2'd0;
  logic [1:0]  dest = 2'd0;
  logic [15:0] regData;
  logic [1:0]  readAddr;
  logic [1:0]  writeAddr;
  logic        writeEnable;
  logic [15:0] dataOut;
  logic        busy;
  logic        done;
  logic        zeroFlag;
  logic        carryFlag;

  logic [15:0] regs [4];
  logic        pre_en = 1'b0;
  logic [1:0]  pre_addr = 2'd0;
  logic [15:0] pre_data = 16'h0000;
  int          wr_count = 0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_exec_seq #(.m(2), .n(16)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op),
    .srcA(srcA), .srcB(srcB), .dest(dest), .regData(regData),
    .readAddr(readAddr), .writeAddr(writeAddr), .writeEnable(writeEnable),
    .dataOut(dataOut), .busy(busy), .done(done),
    .zeroFlag(zeroFlag), .carryFlag(carryFlag)
  );

  assign regData = regs[readAddr];

  always @(negedge clk) begin
    if (pre_en) begin
      regs[pre_addr] <= pre_data;
    end else if (writeEnable) begin
      regs[writeAddr] <= dataOut;
      wr_count <= wr_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [1:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en = 1'b1;
    @(negedge clk);
    #1;
    pre_en = 1'b0;
  endtask

  // Drives start for exactly one sampling edge (E0); returns just after E0.
  task automatic issue(input logic [2:0] o, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] d);
    op = o; srcA = a; srcB = b; dest = d; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if ({readAddr, writeAddr, dataOut, writeEnable, busy, done, zeroFlag, carryFlag} !== 25'd0) begin
      bad++;
      $display("FAIL reset_outputs got ra=%h wa=%h do=%h we=%b busy=%b done=%b z=%b c=%b want all 0",
               readAddr, writeAddr, dataOut, writeEnable, busy, done, zeroFlag, carryFlag);
    end
    for (int i = 0; i < 4; i++) preload(i[1:0], 16'h0000);
  endtask

  task automatic test_add();
    preload(2'd0, 16'd5);
    preload(2'd1, 16'd7);
    issue(3'b000, 2'd0, 2'd1, 2'd2);
    total++;
    if (readAddr !== 2'd0 || busy !== 1'b1 || writeEnable !== 1'b0) begin
      bad++; $display("FAIL add_fetch_a got ra=%0d busy=%b we=%b want 0 1 0", readAddr, busy, writeEnable);
    end
    tick();
    total++;
    if (readAddr !== 2'd1 || writeEnable !== 1'b0) begin
      bad++; $display("FAIL add_fetch_b got ra=%0d we=%b want 1 0", readAddr, writeEnable);
    end
    tick();
    total++;
    if (writeEnable !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL add_exec got we=%b done=%b want 0 0", writeEnable, done);
    end
    tick();
    total++;
    if (writeEnable !== 1'b1 || writeAddr !== 2'd2 || dataOut !== 16'd12 ||
        zeroFlag !== 1'b0 || carryFlag !== 1'b0) begin
      bad++; $display("FAIL add_write got we=%b wa=%0d do=%h z=%b c=%b want 1 2 000c 0 0",
                      writeEnable, writeAddr, dataOut, zeroFlag, carryFlag);
    end
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || writeEnable !== 1'b0 || regs[2] !== 16'd12) begin
      bad++; $display("FAIL add_done got done=%b busy=%b we=%b r2=%h want 1 0 0 000c",
                      done, busy, writeEnable, regs[2]);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL add_done_pulse got done=%b want 0", done);
    end
  endtask

  task automatic test_ops();
    logic [2:0]  t_op [9]  = '{3'b000, 3'b001, 3'b001, 3'b110, 3'b111, 3'b101,
                              3'b010, 3'b011, 3'b100};
    logic [1:0]  t_a  [9]  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [1:0]  t_d  [9]  = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2};
    logic [15:0] t_r0 [9]  = '{16'hFFFF, 16'd3, 16'd9, 16'h8001, 16'h1234, 16'h00FF,
                              16'hF0F0, 16'hF0F0, 16'hF0F0};
    logic [15:0] t_r1 [9]  = '{16'h0001, 16'd5, 16'd9, 16'h0000, 16'h0003, 16'h0000,
                              16'h3C3C, 16'h3C3C, 16'h3C3C};
    logic [15:0] t_exp [9] = '{16'h0000, 16'hFFFE, 16'h0000, 16'h0002, 16'h0001, 16'hFF00,
                              16'h3030, 16'hFCFC, 16'hCCCC};
    logic        t_z  [9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        t_c  [9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 9; k++) begin
      int cyc;
      preload(2'd0, t_r0[k]);
      preload(2'd1, t_r1[k]);
      issue(t_op[k], t_a[k], 2'd1, t_d[k]);
      cyc = 1;
      while (done !== 1'b1 && cyc < 10) begin
        tick();
        cyc++;
      end
      total++;
      if (cyc !== 5 || regs[t_d[k]] !== t_exp[k] || zeroFlag !== t_z[k] || carryFlag !== t_c[k]) begin
        bad++;
        $display("FAIL op_%0d got edges=%0d r%0d=%h z=%b c=%b want 5 %h %b %b",
                 k, cyc, t_d[k], regs[t_d[k]], zeroFlag, carryFlag, t_exp[k], t_z[k], t_c[k]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int w0, dones, busy_e5;
    preload(2'd0, 16'd1);
    preload(2'd1, 16'd2);
    w0 = wr_count;
    dones = 0;
    busy_e5 = 0;
    op = 3'b000; srcA = 2'd0; srcB = 2'd1; dest = 2'd0; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) dones++;
      if (i == 5 && busy === 1'b1) busy_e5 = 1;
    end
    start = 1'b0;
    tick();
    tick();
    total++;
    if (wr_count - w0 !== 2 || dones !== 2 || busy_e5 !== 1 || regs[0] !== 16'd5 || busy !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back got writes=%0d dones=%0d busy_e5=%0d r0=%h busy=%b want 2 2 1 0005 0",
               wr_count - w0, dones, busy_e5, regs[0], busy);
    end
  endtask

  task automatic test_busy_ignore();
    int w0;
    preload(2'd0, 16'h5555);
    preload(2'd1, 16'h0F0F);
    preload(2'd2, 16'h00FF);
    w0 = wr_count;
    issue(3'b100, 2'd1, 2'd2, 2'd3);
    op = 3'b101; srcA = 2'd2; srcB = 2'd2; dest = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (wr_count - w0 !== 1 || regs[3] !== 16'h0FF0 || regs[0] !== 16'h5555 || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_ignore got writes=%0d r3=%h r0=%h busy=%b want 1 0ff0 5555 0",
               wr_count - w0, regs[3], regs[0], busy);
    end
  endtask

  task automatic test_clr_mid();
    int w0, seen;
    preload(2'd0, 16'h1111);
    preload(2'd1, 16'h2222);
    preload(2'd2, 16'hAAAA);
    w0 = wr_count;
    issue(3'b000, 2'd0, 2'd1, 2'd2);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if ({readAddr, writeAddr, dataOut, writeEnable, busy, done, zeroFlag, carryFlag} !== 25'd0) begin
      bad++;
      $display("FAIL clr_fetch_b got ra=%h wa=%h do=%h we=%b busy=%b done=%b z=%b c=%b want all 0",
               readAddr, writeAddr, dataOut, writeEnable, busy, done, zeroFlag, carryFlag);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (wr_count - w0 !== 0 || seen !== 0 || regs[2] !== 16'hAAAA) begin
      bad++;
      $display("FAIL clr_no_write got writes=%0d activity=%0d r2=%h want 0 0 aaaa",
               wr_count - w0, seen, regs[2]);
    end
    issue(3'b000, 2'd0, 2'd1, 2'd2);
    tick();
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || regs[2] !== 16'h3333) begin
      bad++;
      $display("FAIL clr_at_write_end got done=%b busy=%b r2=%h want 0 0 3333", done, busy, regs[2]);
    end
  endtask

  task automatic test_clr_start();
    clr = 1'b1;
    op = 3'b000; srcA = 2'd0; srcB = 2'd1; dest = 2'd2; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (busy !== 1'b0 || readAddr !== 2'd0) begin
        bad++; $display("FAIL clr_with_start got busy=%b ra=%0d want 0 0", busy, readAddr);
      end
    end
    start = 1'b0;
    clr = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL clr_release_idle got busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_back_to_back();
    test_busy_ignore();
    test_clr_mid();
    test_clr_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
